// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage rv32i pipeline
// (IF, ID, EX, MEM, WB).
//   - Issues and tracks the I-cache and D-cache requests.
//   - Freezes the whole pipe while either request is outstanding.
//   - Inserts load-use bubbles.
//   - Sequences branch-mispredict flushes, including throwing away a fetch
//     that was already in flight when the redirect arrived.
//   - Keeps saturating stall/flush counters for performance debug.
//
// Parameters
//   CNT_W         width of each performance counter
//   NOP_ON_FLUSH  1: flushed stage registers load a bubble, 0: they clear to
//                 zero. That choice is made inside the stage registers; this
//                 block only drives their flush strobes.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   inst_resp, data_resp          I-/D-cache response strobes
//   mem_rd_req, mem_wr_req        EX_MEM holds a load / a store
//   id_rs1, id_rs2                source registers decoded in ID
//   id_use_rs1, id_use_rs2        ID instruction reads that source
//   ex_rd, ex_is_load             destination / load flag of ID_EX
//   br_mispredict                 redirect pulse from MEM
//   inst_read                     I-cache read strobe
//   data_read, data_write         D-cache strobes
//   hold_if .. hold_wb            stage register keeps its value
//   flush_if_id, flush_id_ex      load a bubble into that stage register
//   fetch_valid                   inst_rdata being captured is usable
//   stall_mem_cnt, stall_lu_cnt,
//   flush_cnt                     saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int NOP_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_resp,
  input  logic             data_resp,
  input  logic             mem_rd_req,
  input  logic             mem_wr_req,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             br_mispredict,
  output logic             inst_read,
  output logic             data_read,
  output logic             data_write,
  output logic             hold_if,
  output logic             hold_id,
  output logic             hold_ex,
  output logic             hold_mem,
  output logic             hold_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] stall_lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Catch an illegal bubble-mode setting at elaboration.
  if (NOP_ON_FLUSH != 0 && NOP_ON_FLUSH != 1) begin : g_bad_nop_on_flush
    $error("pipeline_hazard_ctrl: NOP_ON_FLUSH must be 0 or 1");
  end

  // Fetch FSM encoding
  localparam logic [1:0] F_REQ     = 2'd0;
  localparam logic [1:0] F_WAIT    = 2'd1;
  localparam logic [1:0] F_DONE    = 2'd2;
  localparam logic [1:0] F_DISCARD = 2'd3;

  // Data FSM encoding
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_WAIT = 2'd1;
  localparam logic [1:0] D_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] f_state, f_next;
  logic [1:0] d_state, d_next;
  logic       flush_pend;

  logic f_issuing;      // an I-cache request is on the bus this cycle
  logic f_usable;       // the request in flight is for the current path
  logic fetch_pending;  // fetch not complete this cycle
  logic d_access;       // a D-cache request is on the bus this cycle
  logic data_pending;   // data access not complete this cycle
  logic mem_stall;
  logic flush_req;
  logic flush_now;
  logic lu_hazard;
  logic lu_now;

  // ---------------------------------------------------------------------------
  // Stall / hazard detection. Everything here is combinational on the resp
  // inputs, so a response releases the freeze in the very cycle it arrives.
  // ---------------------------------------------------------------------------
  assign f_usable      = (f_state == F_REQ) || (f_state == F_WAIT);
  assign f_issuing     = f_usable || (f_state == F_DISCARD);
  // A stale response in F_DISCARD still completes the fetch slot; it is only
  // marked unusable through fetch_valid, and the flush bubbles IF_ID anyway.
  assign fetch_pending = f_issuing && !inst_resp;

  assign d_access      = ((d_state == D_IDLE) && (mem_rd_req || mem_wr_req)) ||
                         (d_state == D_WAIT);
  assign data_pending  = d_access && !data_resp;

  assign mem_stall     = fetch_pending || data_pending;

  // A mispredict is acted on in its own cycle when the pipe advances, and is
  // parked in flush_pend otherwise. Repeats while parked merge into one flush.
  assign flush_req     = flush_pend || br_mispredict;
  assign flush_now     = flush_req && !mem_stall;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign lu_hazard     = ex_is_load && (ex_rd != 5'd0) &&
                         ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                          (id_use_rs2 && (id_rs2 == ex_rd)));
  assign lu_now        = lu_hazard && !mem_stall && !flush_now;

  // ---------------------------------------------------------------------------
  // Fetch FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    f_next = f_state;
    case (f_state)
      F_REQ, F_WAIT: begin
        if (inst_resp)          f_next = mem_stall ? F_DONE : F_REQ;
        else if (br_mispredict) f_next = F_DISCARD;
        else                    f_next = F_WAIT;
      end
      F_DONE: begin
        // Instruction already captured; reissue once the pipe moves.
        if (!mem_stall) f_next = F_REQ;
      end
      F_DISCARD: begin
        if (inst_resp) f_next = F_REQ;
      end
      default: f_next = F_REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data FSM next state. D_DONE parks a finished access so the still-held
  // EX_MEM request is not issued a second time while the fetch catches up.
  // ---------------------------------------------------------------------------
  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: begin
        if (mem_rd_req || mem_wr_req) begin
          if (data_resp) d_next = mem_stall ? D_DONE : D_IDLE;
          else           d_next = D_WAIT;
        end
      end
      D_WAIT: begin
        if (data_resp) d_next = mem_stall ? D_DONE : D_IDLE;
      end
      D_DONE: begin
        if (!mem_stall) d_next = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset forces the pipe fully held and flushed with no strobes,
  // from the first reset cycle on, independent of the state registers.
  // Priority: reset, freeze, mispredict flush, load-use bubble, advance.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_read   = 1'b0;
    data_read   = 1'b0;
    data_write  = 1'b0;
    fetch_valid = 1'b0;
    hold_if     = 1'b1;
    hold_id     = 1'b1;
    hold_ex     = 1'b1;
    hold_mem    = 1'b1;
    hold_wb     = 1'b1;
    flush_if_id = 1'b1;
    flush_id_ex = 1'b1;

    if (rst) begin
      inst_read   = f_issuing;
      data_read   = d_access && mem_rd_req;
      data_write  = d_access && mem_wr_req;
      fetch_valid = f_usable && inst_resp;

      if (mem_stall) begin
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
      end else if (flush_now) begin
        hold_if  = 1'b0;
        hold_id  = 1'b0;
        hold_ex  = 1'b0;
        hold_mem = 1'b0;
        hold_wb  = 1'b0;
      end else if (lu_now) begin
        // Keep IF/ID, push a bubble into EX; older stages drain.
        hold_ex     = 1'b0;
        hold_mem    = 1'b0;
        hold_wb     = 1'b0;
        flush_if_id = 1'b0;
      end else begin
        hold_if     = 1'b0;
        hold_id     = 1'b0;
        hold_ex     = 1'b0;
        hold_mem    = 1'b0;
        hold_wb     = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_state       <= F_REQ;
      d_state       <= D_IDLE;
      flush_pend    <= 1'b0;
      stall_mem_cnt <= '0;
      stall_lu_cnt  <= '0;
      flush_cnt     <= '0;
    end else begin
      f_state    <= f_next;
      d_state    <= d_next;
      flush_pend <= flush_req && mem_stall;

      // Counters stick at all-ones instead of wrapping.
      if (mem_stall && (stall_mem_cnt != '1))
        stall_mem_cnt <= stall_mem_cnt + CNT_ONE;
      if (lu_now && (stall_lu_cnt != '1))
        stall_lu_cnt <= stall_lu_cnt + CNT_ONE;
      if (flush_now && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Directed scenarios cover
// reset, fetch latency, data/fetch overlap, load-use, mispredict during a
// miss and counter saturation; a randomized run compares every output each
// cycle against a transaction-level model of the stall/flush rules.
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       inst_resp, data_resp, mem_rd_req, mem_wr_req;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, br_mispredict;

  logic        inst_read, data_read, data_write;
  logic        hold_if, hold_id, hold_ex, hold_mem, hold_wb;
  logic        flush_if_id, flush_id_ex, fetch_valid;
  logic [15:0] stall_mem_cnt, stall_lu_cnt, flush_cnt;

  logic        s_inst_read, s_data_read, s_data_write;
  logic        s_hold_if, s_hold_id, s_hold_ex, s_hold_mem, s_hold_wb;
  logic        s_flush_if_id, s_flush_id_ex, s_fetch_valid;
  logic [3:0]  s_stall_mem_cnt, s_stall_lu_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(16), .NOP_ON_FLUSH(1)) dut (
    .clk(clk), .rst(rst),
    .inst_resp(inst_resp), .data_resp(data_resp),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_mispredict(br_mispredict),
    .inst_read(inst_read), .data_read(data_read), .data_write(data_write),
    .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex),
    .hold_mem(hold_mem), .hold_wb(hold_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fetch_valid(fetch_valid),
    .stall_mem_cnt(stall_mem_cnt), .stall_lu_cnt(stall_lu_cnt),
    .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .NOP_ON_FLUSH(0)) dut_small (
    .clk(clk), .rst(rst),
    .inst_resp(inst_resp), .data_resp(data_resp),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_mispredict(br_mispredict),
    .inst_read(s_inst_read), .data_read(s_data_read), .data_write(s_data_write),
    .hold_if(s_hold_if), .hold_id(s_hold_id), .hold_ex(s_hold_ex),
    .hold_mem(s_hold_mem), .hold_wb(s_hold_wb),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .fetch_valid(s_fetch_valid),
    .stall_mem_cnt(s_stall_mem_cnt), .stall_lu_cnt(s_stall_lu_cnt),
    .flush_cnt(s_flush_cnt)
  );

  // Output bundle: {inst_read, data_read, data_write, hold[if..wb],
  //                 flush_if_id, flush_id_ex, fetch_valid}
  wire [10:0] outs = {inst_read, data_read, data_write,
                      hold_if, hold_id, hold_ex, hold_mem, hold_wb,
                      flush_if_id, flush_id_ex, fetch_valid};
  wire [10:0] s_outs = {s_inst_read, s_data_read, s_data_write,
                        s_hold_if, s_hold_id, s_hold_ex, s_hold_mem, s_hold_wb,
                        s_flush_if_id, s_flush_id_ex, s_fetch_valid};

  localparam logic [4:0] H_ALL  = 5'b11111;
  localparam logic [4:0] H_LU   = 5'b11000;
  localparam logic [4:0] H_NONE = 5'b00000;
  localparam logic [1:0] FL_BOTH = 2'b11;
  localparam logic [1:0] FL_IDEX = 2'b01;
  localparam logic [1:0] FL_NONE = 2'b00;

  function automatic logic [10:0] ev(input logic ir, input logic dr,
                                     input logic dw, input logic [4:0] h,
                                     input logic [1:0] fl, input logic fv);
    return {ir, dr, dw, h, fl, fv};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic idle_inputs();
    inst_resp = 0; data_resp = 0; mem_rd_req = 0; mem_wr_req = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; br_mispredict = 0;
  endtask

  // Leaves the bench at a negedge with rst released: the first cycle after
  // reset is the one about to be driven.
  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst = 0;
    mem_rd_req = 1;        // must not leak a strobe while in reset
    br_mispredict = 1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (outs !== ev(0, 0, 0, H_ALL, FL_BOTH, 0)) begin
        n_errors++;
        $display("FAIL reset_outs cyc%0d: got %b want %b", c, outs,
                 ev(0, 0, 0, H_ALL, FL_BOTH, 0));
      end
      n_checks++;
      if ({stall_mem_cnt, stall_lu_cnt, flush_cnt} !== 48'd0) begin
        n_errors++;
        $display("FAIL reset_cnt cyc%0d: got %h/%h/%h want 0/0/0", c,
                 stall_mem_cnt, stall_lu_cnt, flush_cnt);
      end
      @(negedge clk);
    end
    idle_inputs();
    rst = 1;
    #1;
    n_checks++;
    if (outs !== ev(1, 0, 0, H_ALL, FL_NONE, 0)) begin
      n_errors++;
      $display("FAIL reset_release_outs: got %b want %b", outs,
               ev(1, 0, 0, H_ALL, FL_NONE, 0));
    end
    n_checks++;
    if ({stall_mem_cnt, stall_lu_cnt, flush_cnt} !== 48'd0) begin
      n_errors++;
      $display("FAIL reset_release_cnt: got %h/%h/%h want 0/0/0",
               stall_mem_cnt, stall_lu_cnt, flush_cnt);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fetch_latency();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      inst_resp = (c == 4);
      exp = (c == 4) ? ev(1, 0, 0, H_NONE, FL_NONE, 1)
                     : ev(1, 0, 0, H_ALL, FL_NONE, 0);
      #1;
      n_checks++;
      if (outs !== exp) begin
        n_errors++;
        $display("FAIL fetch_lat cyc%0d: got %b want %b", c, outs, exp);
      end
      @(negedge clk);
    end
    inst_resp = 0;
    #1;
    n_checks++;
    if (stall_mem_cnt !== 16'd4 || inst_read !== 1'b1) begin
      n_errors++;
      $display("FAIL fetch_lat_cnt: got cnt=%0d ird=%b want cnt=4 ird=1",
               stall_mem_cnt, inst_read);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overlap();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      mem_rd_req = (c <= 5);
      data_resp  = (c == 2);
      inst_resp  = (c == 5);
      case (c)
        0, 1, 2: exp = ev(1, 1, 0, H_ALL, FL_NONE, 0);
        3, 4:    exp = ev(1, 0, 0, H_ALL, FL_NONE, 0);
        5:       exp = ev(1, 0, 0, H_NONE, FL_NONE, 1);
        default: exp = ev(1, 0, 0, H_ALL, FL_NONE, 0);
      endcase
      #1;
      n_checks++;
      if (outs !== exp) begin
        n_errors++;
        $display("FAIL overlap cyc%0d: got %b want %b", c, outs, exp);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++;
    if (stall_mem_cnt !== 16'd6) begin
      n_errors++;
      $display("FAIL overlap_cnt: got %0d want 6", stall_mem_cnt);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    logic [10:0] exp;
    do_reset();
    inst_resp = 1;   // keep the fetch side complete so the pipe can advance
    for (int c = 0; c <= 5; c++) begin
      ex_is_load = 1; id_use_rs1 = 1; id_use_rs2 = 1;
      case (c)
        0: begin ex_rd = 5; id_rs1 = 3; id_rs2 = 5; end               // rs2 hit
        1: begin ex_is_load = 0; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; end
        2: begin ex_rd = 0; id_rs1 = 0; id_rs2 = 0; end               // x0
        3: begin ex_rd = 7; id_rs1 = 7; id_rs2 = 7;
                 id_use_rs1 = 0; id_use_rs2 = 0; end                   // unused
        4: begin ex_rd = 7; id_rs1 = 7; id_rs2 = 1; id_use_rs2 = 0; end // rs1 hit
        default: begin ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; end
      endcase
      exp = (c == 0 || c == 4) ? ev(1, 0, 0, H_LU, FL_IDEX, 1)
                               : ev(1, 0, 0, H_NONE, FL_NONE, 1);
      #1;
      n_checks++;
      if (outs !== exp) begin
        n_errors++;
        $display("FAIL load_use cyc%0d: got %b want %b", c, outs, exp);
      end
      if (c == 1 || c == 5) begin
        n_checks++;
        if (stall_lu_cnt !== ((c == 1) ? 16'd1 : 16'd2)) begin
          n_errors++;
          $display("FAIL load_use_cnt cyc%0d: got %0d want %0d", c,
                   stall_lu_cnt, (c == 1) ? 1 : 2);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mispredict_miss();
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      mem_rd_req    = (c <= 5);
      br_mispredict = (c == 1 || c == 2);   // second pulse must be absorbed
      inst_resp     = (c == 3 || c == 5 || c == 7);
      data_resp     = (c == 4);
      case (c)
        0, 1, 2, 3, 4: exp = ev(1, 1, 0, H_ALL, FL_NONE, 0);
        5:             exp = ev(1, 0, 0, H_NONE, FL_BOTH, 1);
        6:             exp = ev(1, 0, 0, H_ALL, FL_NONE, 0);
        default:       exp = ev(1, 0, 0, H_NONE, FL_NONE, 1);
      endcase
      #1;
      n_checks++;
      if (outs !== exp) begin
        n_errors++;
        $display("FAIL mispredict cyc%0d: got %b want %b", c, outs, exp);
      end
      if (c == 4 || c == 6) begin
        n_checks++;
        if (flush_cnt !== ((c == 4) ? 16'd0 : 16'd1)) begin
          n_errors++;
          $display("FAIL mispredict_cnt cyc%0d: got %0d want %0d", c,
                   flush_cnt, (c == 4) ? 0 : 1);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      #1;
      if (c == 15 || c == 20) begin
        n_checks++;
        if (s_stall_mem_cnt !== 4'd15) begin
          n_errors++;
          $display("FAIL sat_small cyc%0d: got %0d want 15", c, s_stall_mem_cnt);
        end
      end
      if (c == 20) begin
        n_checks++;
        if (stall_mem_cnt !== 16'd20) begin
          n_errors++;
          $display("FAIL sat_wide: got %0d want 20", stall_mem_cnt);
        end
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against a request/response level model:
  //   m_fout  an I-cache request is outstanding (strobe up)
  //   m_fdisc that outstanding request belongs to the wrong path
  //   m_dgot  the current EX_MEM access has been served, waiting to advance
  //   m_pend  a mispredict is waiting for the pipe to advance
  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit m_fout, m_fdisc, m_dgot, m_pend, adv_prev;
    bit d_issue, stall, fl_req, fl_now, hz, lu;
    int m_stall, m_lu, m_fl, r;
    logic [4:0]  h;
    logic [1:0]  fl;
    logic [10:0] exp;
    logic [47:0] exp_cnt;
    logic [11:0] exp_s_cnt;
    do_reset();
    m_fout = 1; m_fdisc = 0; m_dgot = 0; m_pend = 0; adv_prev = 1;
    m_stall = 0; m_lu = 0; m_fl = 0;
    for (int c = 0; c < 1500; c++) begin
      if (adv_prev) begin
        r = $urandom_range(0, 3);
        mem_rd_req = (r == 0);
        mem_wr_req = (r == 1);
      end
      inst_resp     = $urandom_range(0, 1);
      data_resp     = ($urandom_range(0, 99) < 40);
      br_mispredict = ($urandom_range(0, 99) < 6);
      ex_is_load    = $urandom_range(0, 1);
      ex_rd         = 5'($urandom_range(0, 3));
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1);
      id_use_rs2    = $urandom_range(0, 1);

      d_issue = (mem_rd_req || mem_wr_req) && !m_dgot;
      stall   = (m_fout && !inst_resp) || (d_issue && !data_resp);
      fl_req  = m_pend || br_mispredict;
      fl_now  = fl_req && !stall;
      hz      = ex_is_load && (ex_rd != 0) &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      lu      = hz && !stall && !fl_now;
      h  = stall ? H_ALL : (fl_now ? H_NONE : (lu ? H_LU : H_NONE));
      fl = stall ? FL_NONE : (fl_now ? FL_BOTH : (lu ? FL_IDEX : FL_NONE));
      exp = ev(m_fout, d_issue && mem_rd_req, d_issue && mem_wr_req, h, fl,
               m_fout && !m_fdisc && inst_resp);
      exp_cnt   = {16'(sat(m_stall, 65535)), 16'(sat(m_lu, 65535)),
                   16'(sat(m_fl, 65535))};
      exp_s_cnt = {4'(sat(m_stall, 15)), 4'(sat(m_lu, 15)), 4'(sat(m_fl, 15))};

      #1;
      n_checks++;
      if (outs !== exp || s_outs !== exp) begin
        n_errors++;
        $display("FAIL rand_outs cyc%0d: got %b/%b want %b", c, outs, s_outs, exp);
      end
      n_checks++;
      if ({stall_mem_cnt, stall_lu_cnt, flush_cnt} !== exp_cnt ||
          {s_stall_mem_cnt, s_stall_lu_cnt, s_flush_cnt} !== exp_s_cnt) begin
        n_errors++;
        $display("FAIL rand_cnt cyc%0d: got %h/%h want %h/%h", c,
                 {stall_mem_cnt, stall_lu_cnt, flush_cnt},
                 {s_stall_mem_cnt, s_stall_lu_cnt, s_flush_cnt},
                 exp_cnt, exp_s_cnt);
      end

      // Model update for the coming clock edge.
      if (m_fout) begin
        if (inst_resp) begin
          if (m_fdisc)    m_fdisc = 0;         // stale word dropped, refetch
          else if (stall) m_fout  = 0;         // captured, wait for advance
        end else if (br_mispredict) begin
          m_fdisc = 1;
        end
      end else if (!stall) begin
        m_fout = 1;
      end
      if (d_issue && data_resp && stall) m_dgot = 1;
      else if (m_dgot && !stall)         m_dgot = 0;
      m_pend = fl_req && stall;
      if (stall)  m_stall++;
      if (lu)     m_lu++;
      if (fl_now) m_fl++;
      adv_prev = !stall;

      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_fetch_latency();
    test_overlap();
    test_load_use();
    test_mispredict_miss();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage rv32i pipeline (IF, ID, EX, MEM, WB).
- Issues and tracks I-cache and D-cache requests, freezes the pipe while either is outstanding, and inserts load-use bubbles.
- Sequences branch-mispredict flushes, including discarding a fetch that was in flight at redirect time.
- Drives the hold/flush inputs of every stage register and keeps saturating stall counters for performance debug.

Parameters:
- CNT_W, 16, width of each performance counter.
- NOP_ON_FLUSH, 1: 1 means flushed stage registers load a bubble; 0 means they are cleared to zero.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset
- inst_resp  in  1  I-cache response; rdata valid this cycle
- data_resp  in  1  D-cache response
- mem_rd_req  in  1  EX_MEM stage holds a load
- mem_wr_req  in  1  EX_MEM stage holds a store
- id_rs1, id_rs2  in  5 each  source registers decoded in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- ex_rd  in  5  destination register of the ID_EX instruction
- ex_is_load  in  1  ID_EX instruction is a load
- br_mispredict  in  1  redirect from MEM stage; pulse
- inst_read  out  1  I-cache read strobe
- data_read, data_write  out  1 each  D-cache strobes
- hold_if, hold_id, hold_ex, hold_mem, hold_wb  out  1 each  stage register keeps its value
- flush_if_id, flush_id_ex  out  1 each  load a bubble into that stage register
- fetch_valid  out  1  the inst_rdata being captured is usable
- stall_mem_cnt, stall_lu_cnt, flush_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset: rst low at a clk edge clears all state. Outputs while in reset:
  - inst_read=0, data_read=0, data_write=0, fetch_valid=0.
  - All hold_*=1, both flush_*=1, counters=0.
  - First cycle after rst rises: inst_read=1.
- Fetch FSM, states F_REQ, F_WAIT, F_DONE, F_DISCARD:
  - F_REQ: inst_read=1. inst_resp the same cycle with pipe advancing: stay in F_REQ. inst_resp while pipe frozen: go to F_DONE. No inst_resp: go to F_WAIT.
  - F_WAIT: inst_read=1. Transitions on inst_resp are the same as from F_REQ.
  - F_DONE: inst_read=0. Instruction already latched by IF_ID; wait for the pipe to advance, then go to F_REQ.
  - F_DISCARD: entered when br_mispredict arrives while a request is outstanding (F_REQ/F_WAIT without inst_resp). inst_read stays 1 until inst_resp, then go to F_REQ. fetch_valid=0 for that response.
- Data FSM, states D_IDLE, D_WAIT, D_DONE:
  - D_IDLE: on mem_rd_req or mem_wr_req, assert the matching strobe the same cycle. data_resp the same cycle: done, stay in D_IDLE. Otherwise go to D_WAIT.
  - D_WAIT: keep the strobe at 1 until data_resp.
  - D_DONE: entered when data_resp arrives but the fetch is still pending. Strobes are 0 (no re-issue); return to D_IDLE when the pipe advances.
- Global freeze (mem_stall) = fetch not complete OR data access not complete.
  - Both conditions are combinational on the resp inputs, so a resp clears the stall in the same cycle it arrives.
  - While frozen: all hold_*=1, no flush_* is applied, and stall_mem_cnt increments.
- Load-use hazard (lu) = ex_is_load AND ex_rd!=0 AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)).
  - When lu and not mem_stall: hold_if=hold_id=1 and flush_id_ex=1 for exactly one cycle, and stall_lu_cnt increments.
  - x0 never hazards.
- Mispredict:
  - br_mispredict is latched into flush_pend.
  - On the first advancing cycle (not mem_stall): flush_if_id=flush_id_ex=1, flush_cnt increments, flush_pend clears.
  - Flush has priority over lu; lu is suppressed that cycle.
  - A second br_mispredict while flush_pend is set is absorbed and counted once.
- Priority, highest first: rst, mem_stall, flush, lu, normal advance (all hold/flush 0).
- Counters saturate at 2^CNT_W-1 and never wrap.
- Resp with no outstanding request is ignored: no state change, no counter effect.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release. Required: inst_read=0 and all hold_*=1 during reset; inst_read=1 in cycle 1 after release; counters=0.
- Fetch latency: inst_resp arrives 4 cycles after inst_read, no data traffic. Required: hold_* high for 4 cycles, low on the resp cycle; stall_mem_cnt=4.
- Overlap: load issued with data_resp at cycle 2 and inst_resp at cycle 5. Required: state D_DONE on cycles 3-5 with data_read=0; pipe advances at cycle 5; no second data_read.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1. Required: one cycle of hold_if=hold_id=1 and flush_id_ex=1; stall_lu_cnt=1. Repeat with ex_rd=0: no stall.
- Mispredict during miss: br_mispredict pulses while in F_WAIT and the D-cache is stalled. Required: flush deferred until unfreeze; stale inst_resp gives fetch_valid=0; flush_cnt=1; a new inst_read follows.
- Saturation with CNT_W=4: 20 stall cycles. Required: stall_mem_cnt=15 and holds.
